// File: rtl/usb_tx_wire_writer_if.sv
// Write side of the SIE transmit wire: arbitrated symbol stream in, ready back out.
interface usb_tx_wire_writer_if;
   logic [1:0] TxBits;
   logic       TxCtl;
   logic       TxFSRate;
   logic       USBWireWEn;
   logic       USBWireRdy;

   modport master (output TxBits, output TxCtl, output TxFSRate, output USBWireWEn,
                   input  USBWireRdy);
   modport slave  (input  TxBits, input  TxCtl, input  TxFSRate, input  USBWireWEn,
                   output USBWireRdy);
endinterface

// File: rtl/usb_tx_wire_writer.sv
// Buffers line symbols and replays each onto the transceiver pins for one
// full-speed or low-speed bit time, back to back when the FIFO stays non-empty.
module usb_tx_wire_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int FS_DIV     = 4,
   parameter int LS_DIV     = 32
) (
   input  logic                clk,
   input  logic                rst,
   usb_tx_wire_writer_if.slave wr,
   output logic [1:0]          USBWireDataOut,
   output logic                USBWireCtrlOut,
   output logic                USBWireFullSpeedRate,
   output logic                USBWireActive
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int BW  = $clog2(LS_DIV);
   localparam logic [BW-1:0] FS_LOAD = BW'(FS_DIV - 1);
   localparam logic [BW-1:0] LS_LOAD = BW'(LS_DIV - 1);
   localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [1:0] bits;
      logic       ctl;
      logic       fs;
   } sym_t;

   typedef enum logic {IDLE, HOLD} state_t;

   sym_t            mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [BW-1:0]   bit_cnt;
   state_t          state, state_nxt;
   logic            push, pop, fifo_ne;
   sym_t            head;

   // Ready comes straight from the occupancy register, never from the strobe.
   assign wr.USBWireRdy = (count != FULL);
   assign push          = wr.USBWireWEn && wr.USBWireRdy;
   assign fifo_ne       = (count != '0);
   assign head          = mem[rd_ptr];
   assign USBWireActive = (state == HOLD);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{bits: wr.TxBits, ctl: wr.TxCtl, fs: wr.TxFSRate};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_ne) begin
               pop       = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            // Reload on the last cycle of a bit time so consecutive symbols abut.
            if (bit_cnt == '0) begin
               if (fifo_ne) pop = 1'b1;
               else         state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         USBWireDataOut       <= 2'b00;
         USBWireCtrlOut       <= 1'b0;
         USBWireFullSpeedRate <= 1'b1;
         bit_cnt              <= '0;
      end else if (pop) begin
         USBWireDataOut       <= head.bits;
         USBWireCtrlOut       <= head.ctl;
         USBWireFullSpeedRate <= head.fs;
         bit_cnt              <= head.fs ? FS_LOAD : LS_LOAD;
      end else if (state == HOLD && bit_cnt != '0) begin
         bit_cnt <= bit_cnt - BW'(1);
      end
   end

endmodule

// File: tb/tb_usb_tx_wire_writer.sv
// Directed and random symbol streams checked cycle by cycle against a
// timeline model: each accepted symbol owns an interval [start, stop] on the wire.
module tb_usb_tx_wire_writer;
   localparam int DEPTH = 4;
   localparam int FSD   = 4;
   localparam int LSD   = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   usb_tx_wire_writer_if wr ();
   logic [1:0] data;
   logic       ctrl, fsr, active;

   usb_tx_wire_writer #(.FIFO_DEPTH(DEPTH), .FS_DIV(FSD), .LS_DIV(LSD)) dut (
      .clk(clk), .rst(rst), .wr(wr.slave),
      .USBWireDataOut(data), .USBWireCtrlOut(ctrl),
      .USBWireFullSpeedRate(fsr), .USBWireActive(active)
   );

   typedef struct {
      logic [1:0] bits;
      logic       ctl;
      logic       fs;
      int         n;
      int         start;
      int         stop;
   } sym_t;

   sym_t q[$];
   int   cyc = 0;
   int   last_stop = -1000;
   int   checks = 0;
   int   errors = 0;
   bit   saw_low = 1'b0;

   // Symbols in the FIFO during cycle c: pushed at an earlier edge, not yet popped
   // (a symbol is popped at the edge just before its start cycle).
   function automatic int occ(int c);
      int k = 0;
      foreach (q[i]) begin
         if (q[i].n < c)      k++;
         if (q[i].start <= c) k--;
      end
      return k;
   endfunction

   task automatic check(int c);
      logic [1:0] ed;
      logic ec, ef, ea, er;
      ed = 2'b00; ec = 1'b0; ef = 1'b1; ea = 1'b0;
      foreach (q[i]) if (q[i].start <= c) begin
         ed = q[i].bits; ec = q[i].ctl; ef = q[i].fs; ea = (q[i].stop >= c);
      end
      er = (occ(c) != DEPTH);
      checks++;
      assert (data === ed) else begin errors++; $error("FAIL data cyc=%0d got %b exp %b", c, data, ed); end
      checks++;
      assert (ctrl === ec) else begin errors++; $error("FAIL ctrl cyc=%0d got %b exp %b", c, ctrl, ec); end
      checks++;
      assert (fsr === ef) else begin errors++; $error("FAIL fsrate cyc=%0d got %b exp %b", c, fsr, ef); end
      checks++;
      assert (active === ea) else begin errors++; $error("FAIL active cyc=%0d got %b exp %b", c, active, ea); end
      checks++;
      assert (wr.USBWireRdy === er) else begin errors++; $error("FAIL rdy cyc=%0d got %b exp %b", c, wr.USBWireRdy, er); end
      if (wr.USBWireRdy === 1'b0) saw_low = 1'b1;
   endtask

   // One clock cycle: drive inputs mid-cycle, check outputs, update the model.
   task automatic step(input bit w, input logic [1:0] b, input logic c, input logic f, input bit r);
      sym_t s;
      rst = r;
      wr.USBWireWEn = w; wr.TxBits = b; wr.TxCtl = c; wr.TxFSRate = f;
      check(cyc);
      if (r) begin
         q.delete();
         last_stop = -1000;
      end else if (w && occ(cyc) != DEPTH) begin
         s.bits = b; s.ctl = c; s.fs = f; s.n = cyc;
         s.start = (cyc + 2 > last_stop + 1) ? cyc + 2 : last_stop + 1;
         s.stop  = s.start + (f ? FSD : LSD) - 1;
         last_stop = s.stop;
         q.push_back(s);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(int k);
      for (int i = 0; i < k; i++) step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic bound_ok(bit ok, string tag);
      checks++;
      assert (ok) else begin errors++; $error("FAIL %s got timeout exp completion", tag); end
   endtask

   initial begin
      int sent, g, target;
      logic [3:0] sym4;
      wr.USBWireWEn = 1'b0; wr.TxBits = 2'b00; wr.TxCtl = 1'b0; wr.TxFSRate = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state and quiet line
      idle(100);

      // single full-speed symbol
      step(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
      idle(10);

      // back-to-back stream of 8 FS symbols, pushed whenever ready
      saw_low = 1'b0;
      sent = 0; g = 0;
      while (sent < 8 && g < 200) begin
         if (occ(cyc) != DEPTH) begin
            sym4 = 4'(sent * 5 + 3);
            step(1'b1, sym4[3:2], sym4[1], 1'b1, 1'b0);
            sent++;
         end else idle(1);
         g++;
      end
      bound_ok(sent == 8, "b2b_push");
      idle(40);
      checks++;
      assert (saw_low === 1'b1) else begin errors++; $error("FAIL rdy_drop got %b exp %b", saw_low, 1'b1); end

      // mixed rates FS, LS, FS
      step(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
      step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
      idle(50);

      // overflow: LS symbol occupies the wire while A..D fill the FIFO, E is dropped
      step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
      step(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
      step(1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
      step(1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
      idle(80);

      // reset in the 2nd cycle of the 2nd of 4 queued symbols
      for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b1, 1'b1, 1'b0);
      target = q[q.size() - 3].start + 1;
      g = 0;
      while (cyc < target && g < 50) begin idle(1); g++; end
      bound_ok(cyc == target, "reset_align");
      step(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
      idle(40);

      // random traffic
      for (int i = 0; i < 600; i++)
         step(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) == 0));
      idle(120);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
